mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_access_load_align.sv | 26 ++
 rtl/mem_access.sv | 173 +++++++++++++++++
 tb/tb_mem_access.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: access sizes and FSM states.
package mem_access_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    SIZE_B  = 3'd0,
    SIZE_H  = 3'd1,
    SIZE_W  = 3'd2,
    SIZE_BU = 3'd3,
    SIZE_HU = 3'd4
  } data_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_load_align.sv
// Load data extraction: shift the addressed bytes down and sign/zero extend.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  data_size_e        size,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (size)
      SIZE_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      SIZE_BU: data = {24'd0, shifted[7:0]};
      SIZE_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      SIZE_HU: data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding data bus master with writeback.
// Optional build macro MEM_MISALIGN_TRAP_EN adds misaligned-access trapping (misalign_o).
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        sel_rd_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  data_size_e        mem_size_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] rs2_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              rd_we_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        sel_rd_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              stall_o
);

  state_e            state;
  logic [DATA_W-1:0] lat_addr, lat_wdata;
  logic [3:0]        lat_be;
  logic              lat_we;
  data_size_e        lat_size;
  logic [1:0]        lat_off;
  logic [4:0]        lat_rd;

  logic              misalign, access;
  logic [3:0]        be_in;
  logic [DATA_W-1:0] wdata_in, load_data;

  always_comb begin
    be_in    = 4'hF;
    wdata_in = rs2_i;
    case (mem_size_i)
      SIZE_B, SIZE_BU: begin
        be_in    = 4'b0001 << alu_result_i[1:0];
        wdata_in = {4{rs2_i[7:0]}};
      end
      SIZE_H, SIZE_HU: begin
        be_in    = 4'b0011 << {alu_result_i[1], 1'b0};
        wdata_in = {2{rs2_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_re_i || mem_we_i) begin
      case (mem_size_i)
        SIZE_H, SIZE_HU: misalign = alu_result_i[0];
        SIZE_W:          misalign = |alu_result_i[1:0];
        default:         misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign access = (mem_re_i || mem_we_i) && !misalign;

  // Bus outputs come straight from execute in IDLE, from the latch once the request is parked.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = mem_we_i;
    dmem_addr_o  = {alu_result_i[31:2], 2'b00};
    dmem_be_o    = be_in;
    dmem_wdata_o = wdata_in;
    stall_o      = 1'b0;
    case (state)
      IDLE: begin
        dmem_req_o = access;
        stall_o    = access && (!dmem_gnt_i || !mem_we_i);
      end
      REQ, WAIT_R: begin
        dmem_we_o    = lat_we;
        dmem_addr_o  = lat_addr;
        dmem_be_o    = lat_be;
        dmem_wdata_o = lat_wdata;
        if (state == REQ) begin
          dmem_req_o = 1'b1;
          stall_o    = !(dmem_gnt_i && lat_we);
        end else begin
          stall_o    = !dmem_rvalid_i;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
    end
  end

  mem_access_load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .offset (lat_off),
    .size   (lat_size),
    .data   (load_data)
  );

  // Writeback defaults to a bubble every cycle; only a retiring op overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_we     <= 1'b0;
      lat_size   <= SIZE_B;
      lat_off    <= '0;
      lat_rd     <= '0;
      rd_we_o    <= 1'b0;
      rd_data_o  <= '0;
      sel_rd_o   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      rd_we_o    <= 1'b0;
      sel_rd_o   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= misalign && (state == IDLE);
`endif
      case (state)
        IDLE: begin
          if (access) begin
            lat_addr  <= {alu_result_i[31:2], 2'b00};
            lat_wdata <= wdata_in;
            lat_be    <= be_in;
            lat_we    <= mem_we_i;
            lat_size  <= mem_size_i;
            lat_off   <= alu_result_i[1:0];
            lat_rd    <= sel_rd_i;
            if (!dmem_gnt_i)    state <= REQ;
            else if (!mem_we_i) state <= WAIT_R;
          end else if (!misalign) begin
            rd_data_o <= alu_result_i;
            rd_we_o   <= |sel_rd_i;
            sel_rd_o  <= sel_rd_i;
          end
        end
        REQ: begin
          if (dmem_gnt_i) state <= lat_we ? IDLE : WAIT_R;
        end
        WAIT_R: begin
          if (dmem_rvalid_i) begin
            rd_data_o <= load_data;
            rd_we_o   <= |lat_rd;
            sel_rd_o  <= lat_rd;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table, random transactions vs. a
// transaction-level model, and hand-written reset/stall/misalign sequences.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk, rst_n;
  logic [4:0]  sel_rd_i, sel_rd_o;
  logic        mem_re_i, mem_we_i;
  data_size_e  mem_size_i;
  logic [31:0] alu_result_i, rs2_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rd_we_o;
  logic [31:0] rd_data_o;
  logic        stall_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  mem_access dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_rd_i      (sel_rd_i),
    .mem_re_i      (mem_re_i),
    .mem_we_i      (mem_we_i),
    .mem_size_i    (mem_size_i),
    .alu_result_i  (alu_result_i),
    .rs2_i         (rs2_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rd_we_o       (rd_we_o),
    .rd_data_o     (rd_data_o),
    .sel_rd_o      (sel_rd_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o    (misalign_o),
`endif
    .stall_o       (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cur_id = 0;

  typedef struct {
    logic        re;
    logic        we;
    data_size_e  sz;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        ewe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (txn %0d): got 0x%08h expected 0x%08h", name, cur_id, act, exp);
    end
  endtask

  // Reference model: byte-lane view of the bus, independent of any FSM.
  function automatic logic [3:0] model_be(data_size_e s, logic [31:0] a);
    int lane = int'(a[1:0]);
    case (s)
      SIZE_B, SIZE_BU: return 4'(1 << lane);
      SIZE_H, SIZE_HU: return (lane >= 2) ? 4'b1100 : 4'b0011;
      default:         return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(data_size_e s, logic [31:0] d);
    case (s)
      SIZE_B, SIZE_BU: return (d & 32'hFF) * 32'h0101_0101;
      SIZE_H, SIZE_HU: return (d & 32'hFFFF) * 32'h0001_0001;
      default:         return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(data_size_e s, logic [31:0] a, logic [31:0] rdata);
    logic [7:0] b [4];
    int off = int'(a[1:0]);
    longint v;
    for (int k = 0; k < 4; k++) b[k] = rdata[8*k +: 8];
    case (s)
      SIZE_B, SIZE_BU: begin
        v = longint'(b[off]);
        if (s == SIZE_B && v >= 128) v = v - 256;
      end
      SIZE_H, SIZE_HU: begin
        v = longint'(b[off]) + 256 * longint'(b[(off + 1) % 4]);
        if (s == SIZE_H && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdata);
    endcase
    return v[31:0];
  endfunction

  task automatic drive_op(input logic re, input logic we, input data_size_e sz,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
    mem_re_i = re; mem_we_i = we; mem_size_i = sz;
    alu_result_i = addr; rs2_i = rs2; sel_rd_i = rd;
  endtask

  // Entered at posedge+1; plays the upstream stage and the bus slave for one op.
  task automatic run_txn(input vec_t v);
    logic is_mem = v.re || v.we;
    logic load   = v.re && !v.we;
    int   total  = !is_mem ? 0 : (load ? v.gdly + v.rdly : v.gdly);
    for (int c = 0; c <= total; c++) begin
      drive_op(v.re, v.we, v.sz, v.addr, v.rs2, v.rd);
      dmem_gnt_i    = is_mem && (c == v.gdly);
      dmem_rvalid_i = (c <= v.gdly) ? 1'($urandom_range(0, 1)) : (load && c == total);
      dmem_rdata_i  = (c == total) ? v.rdata : $urandom;
      #2;
      chk("dmem_req", 32'(dmem_req_o), 32'(is_mem && c <= v.gdly));
      if (is_mem && c <= v.gdly) begin
        chk("dmem_addr", dmem_addr_o, v.addr & 32'hFFFF_FFFC);
        chk("dmem_be", 32'(dmem_be_o), 32'(v.ebe));
        chk("dmem_we", 32'(dmem_we_o), 32'(v.we));
        if (v.we) chk("dmem_wdata", dmem_wdata_o, v.ewd);
      end
      chk("stall", 32'(stall_o), 32'(c < total));
      @(posedge clk); #1;
      if (c < total) begin
        chk("bubble_we", 32'(rd_we_o), 32'd0);
        chk("bubble_rd", 32'(sel_rd_o), 32'd0);
      end else begin
        chk("rd_we", 32'(rd_we_o), 32'(v.ewe));
        if (v.ewe) begin
          chk("rd_data", rd_data_o, v.erd);
          chk("sel_rd", 32'(sel_rd_o), 32'(v.rd));
        end
      end
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   bubbles;

    //                re    we    size     addr          rs2           rd     rdata         g  r  be       wdata          rd_data        we
    tbl.push_back('{1'b0, 1'b1, SIZE_B,  32'h0000_0103, 32'h0000_00AB, 5'd0,  32'h0,        0, 1, 4'b1000, 32'hABAB_ABAB, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, SIZE_H,  32'h0000_0202, 32'h0,        5'd7,  32'h8001_0000, 0, 3, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b1});
    tbl.push_back('{1'b1, 1'b0, SIZE_BU, 32'h0000_0001, 32'h0,        5'd9,  32'h0000_F000, 1, 1, 4'b0010, 32'h0,        32'h0000_00F0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, SIZE_W,  32'hDEAD_BEEF, 32'h0,        5'd12, 32'h0,        0, 1, 4'h0,    32'h0,        32'hDEAD_BEEF, 1'b1});
    tbl.push_back('{1'b0, 1'b0, SIZE_W,  32'h1357_9BDF, 32'h0,        5'd0,  32'h0,        0, 1, 4'h0,    32'h0,        32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, SIZE_B,  32'h0000_0003, 32'h0,        5'd1,  32'h80FF_FFFF, 0, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b1});
    tbl.push_back('{1'b1, 1'b0, SIZE_B,  32'h0000_0001, 32'h0,        5'd2,  32'h0000_7F00, 0, 2, 4'b0010, 32'h0,        32'h0000_007F, 1'b1});
    tbl.push_back('{1'b1, 1'b0, SIZE_HU, 32'h0000_0002, 32'h0,        5'd3,  32'h8001_0000, 0, 1, 4'b1100, 32'h0,        32'h0000_8001, 1'b1});
    tbl.push_back('{1'b1, 1'b0, SIZE_W,  32'h0000_0010, 32'h0,        5'd31, 32'h1234_5678, 2, 1, 4'hF,    32'h0,        32'h1234_5678, 1'b1});
    tbl.push_back('{1'b1, 1'b0, SIZE_W,  32'h0000_0020, 32'h0,        5'd0,  32'hFFFF_FFFF, 0, 2, 4'hF,    32'h0,        32'h0,        1'b0});
    tbl.push_back('{1'b0, 1'b1, SIZE_H,  32'h0000_0002, 32'h1234_ABCD, 5'd4,  32'h0,        0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 1'b1, SIZE_W,  32'h0000_0044, 32'hCAFE_F00D, 5'd5,  32'h0,        3, 1, 4'hF,    32'hCAFE_F00D, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, SIZE_B,  32'h0000_0001, 32'h0000_005A, 5'd6,  32'h0,        1, 1, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0});

    // Reset state, with a pending load request on the inputs.
    rst_n = 1'b0;
    drive_op(1'b1, 1'b0, SIZE_W, 32'h40, 32'h0, 5'd3);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_we", 32'(rd_we_o), 32'd0);
    chk("rst_sel_rd", 32'(sel_rd_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(misalign_o), 32'd0);
`endif
    drive_op(1'b0, 1'b0, SIZE_W, 32'h0, 32'h0, 5'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cur_id = i;
      run_txn(tbl[i]);
    end

    // Grant withheld two cycles while upstream inputs wander.
    cur_id = 100;
    bubbles = 0;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       drive_op(1'b0, 1'b1, SIZE_W, 32'h40, 32'h1122_3344, 5'd0);
        1:       drive_op(1'b1, 1'b0, SIZE_B, 32'h99, 32'h77, 5'd8);
        default: drive_op(1'b0, 1'b0, SIZE_H, 32'hABC, 32'h55, 5'd3);
      endcase
      dmem_gnt_i = (c == 2);
      #2;
      chk("hold_req", 32'(dmem_req_o), 32'd1);
      chk("hold_addr", dmem_addr_o, 32'h40);
      chk("hold_be", 32'(dmem_be_o), 32'hF);
      chk("hold_we", 32'(dmem_we_o), 32'd1);
      chk("hold_wdata", dmem_wdata_o, 32'h1122_3344);
      if (stall_o) bubbles++;
      @(posedge clk); #1;
      chk("hold_rd_we", 32'(rd_we_o), 32'd0);
    end
    chk("hold_bubbles", 32'(bubbles), 32'd2);
    dmem_gnt_i = 1'b0;

    // Reset while waiting for load data; the late rvalid must be dropped.
    cur_id = 101;
    drive_op(1'b1, 1'b0, SIZE_W, 32'h300, 32'h0, 5'd4);
    dmem_gnt_i = 1'b1;
    #2;
    chk("rstw_req", 32'(dmem_req_o), 32'd1);
    chk("rstw_stall0", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    #1;
    chk("rstw_stall1", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_stall_in_rst", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_op(1'b0, 1'b0, SIZE_W, 32'h55, 32'h0, 5'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hAAAA_AAAA;
    #2;
    chk("rstw_late_stall", 32'(stall_o), 32'd0);
    chk("rstw_late_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    chk("rstw_late_rd_we", 32'(rd_we_o), 32'd0);
    dmem_rvalid_i = 1'b0;
    v = '{1'b0, 1'b0, SIZE_W, 32'h0000_1234, 32'h0, 5'd6, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0000_1234, 1'b1};
    run_txn(v);

`ifdef MEM_MISALIGN_TRAP_EN
    cur_id = 102;
    drive_op(1'b1, 1'b0, SIZE_W, 32'h6, 32'h0, 5'd3);
    dmem_gnt_i = 1'b1;
    #2;
    chk("mis_req", 32'(dmem_req_o), 32'd0);
    chk("mis_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_rd_we", 32'(rd_we_o), 32'd0);
    dmem_gnt_i = 1'b0;
    drive_op(1'b0, 1'b0, SIZE_W, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("mis_clear", 32'(misalign_o), 32'd0);
`endif

    // Random transactions against the model (H/W kept naturally aligned).
    for (int i = 0; i < 200; i++) begin
      cur_id = 1000 + i;
      v.re    = 1'($urandom_range(0, 1));
      v.we    = 1'($urandom_range(0, 1));
      v.sz    = data_size_e'(3'($urandom_range(0, 4)));
      v.addr  = $urandom;
      if (v.sz == SIZE_H || v.sz == SIZE_HU) v.addr[0] = 1'b0;
      if (v.sz == SIZE_W) v.addr[1:0] = 2'b00;
      v.rs2   = $urandom;
      v.rd    = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      v.gdly  = $urandom_range(0, 3);
      v.rdly  = $urandom_range(1, 3);
      v.ebe   = model_be(v.sz, v.addr);
      v.ewd   = model_wd(v.sz, v.rs2);
      if (!v.re && !v.we) begin
        v.ewe = (v.rd != 0);
        v.erd = v.addr;
      end else if (v.we) begin
        v.ewe = 1'b0;
        v.erd = 32'h0;
      end else begin
        v.ewe = (v.rd != 0);
        v.erd = model_load(v.sz, v.addr, v.rdata);
      end
      run_txn(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
